cpu_wb_master: RTL

- Bridges the MIPS core's single-cycle data-memory request strobe onto the Wishbone classic bus as the sole bus master.
- Sits directly upstream of the peripheral slaves, including the GPIO slave at 32'h00000400.
- Runs one transaction at a time and reports completion to the core.
- Guards the core against slaves that never acknowledge, using a watchdog timeout, an error flag and a saturating error counter.

---
 rtl/cpu_wb_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cpu_wb_master.sv
// Bridges the core's one-cycle data-memory strobe onto a Wishbone classic bus as the only master.
// Latency: cyc/stb one cycle after req; done one cycle after ack, or TIMEOUT+1 cycles after req on a timeout.
// Backpressure: a single transaction in flight; a req seen while busy is dropped, never queued.
module cpu_wb_master #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] ERR_VALUE = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    input  logic [3:0]  cpu_sel_i,
    output logic        cpu_busy_o,
    output logic        cpu_done_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_dat_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wdog_q;
    logic       accept;
    logic       ack_hit;
    logic       tmo_hit;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ack takes priority over a watchdog expiring in the same cycle
                if (wb_ack_i) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wdog_q     <= 8'd0;
            cpu_busy_o <= 1'b0;
            cpu_done_o <= 1'b0;
            cpu_err_o  <= 1'b0;
            cpu_dat_o  <= 32'd0;
            wb_adr_o   <= 32'd0;
            wb_dat_o   <= 32'd0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'd0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            err_cnt_o  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cpu_done_o <= 1'b0;
            cpu_err_o  <= 1'b0;

            if (accept) begin
                wb_adr_o   <= cpu_adr_i;
                wb_dat_o   <= cpu_dat_i;
                wb_we_o    <= cpu_we_i;
                wb_sel_o   <= cpu_sel_i;
                wb_cyc_o   <= 1'b1;
                wb_stb_o   <= 1'b1;
                cpu_busy_o <= 1'b1;
                wdog_q     <= 8'd0;
            end

            if (state_q == BUS) begin
                wdog_q <= wdog_q + 8'd1;
            end

            if (ack_hit || tmo_hit) begin
                wb_cyc_o   <= 1'b0;
                wb_stb_o   <= 1'b0;
                cpu_done_o <= 1'b1;
                cpu_err_o  <= tmo_hit;
                if (!wb_we_o) begin
                    cpu_dat_o <= ack_hit ? wb_dat_i : ERR_VALUE;
                end
            end

            if (tmo_hit && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end

            // the DONE cycle keeps busy high so the slave sees one idle cycle before the next strobe
            if (state_q == DONE) begin
                cpu_busy_o <= 1'b0;
            end
        end
    end

endmodule
